// File: rtl/mult_seq_pkg.sv
// Shared constants and state encoding for the sequential 16x16 shift-add multiplier.
package mult_seq_pkg;

  localparam int          MULT_W    = 16;
  localparam int          MULT_ITER = 16;
  localparam logic [3:0]  CNT_LAST  = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mult_seq16_add.sv
// 16-bit ripple-carry adder shared by every multiply iteration; V flags signed overflow.
module Full_Adder_16Bits
  import mult_seq_pkg::*;
(
  input  logic [MULT_W-1:0] X,
  input  logic [MULT_W-1:0] Y,
  input  logic              cin,
  output logic [MULT_W-1:0] S,
  output logic              cout,
  output logic              V
);

  logic [MULT_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < MULT_W; i++) begin : g_fa
    assign S[i]   = X[i] ^ Y[i] ^ c[i];
    assign c[i+1] = (X[i] & Y[i]) | (c[i] & (X[i] ^ Y[i]));
  end

  assign cout = c[MULT_W];
  assign V    = c[MULT_W] ^ c[MULT_W-1];

endmodule

// File: rtl/mult_seq16.sv
// Shift-add multiplier sequencer: one shared adder, 16 iterations, one-cycle done strobe.
module mult_seq16
  import mult_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [MULT_W-1:0]   A,
  input  logic [MULT_W-1:0]   B,
  output logic                busy,
  output logic                done,
  output logic [2*MULT_W-1:0] P
);

  state_t            state;
  state_t            state_next;
  logic [MULT_W-1:0] mcand;
  logic [MULT_W-1:0] hi;
  logic [MULT_W-1:0] lo;
  logic [3:0]        cnt;
  logic [MULT_W-1:0] y;
  logic [MULT_W-1:0] s;
  logic              cout;
  logic              v_unused;

  assign y = lo[0] ? mcand : '0;

  Full_Adder_16Bits u_add (
    .X    (hi),
    .Y    (y),
    .cin  (1'b0),
    .S    (s),
    .cout (cout),
    .V    (v_unused)
  );

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: defaults first, so no path through the case can infer a latch;
  // the encoding 2'b11 falls into the default and returns to IDLE.
  always_comb begin
    state_next = IDLE;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:    state_next = start ? RUN : IDLE;
      RUN: begin
        busy       = 1'b1;
        state_next = (cnt == CNT_LAST) ? DONE : RUN;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: {hi,lo} shifts right by one each RUN cycle with the adder result on top.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      P     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= A;
            lo    <= B;
            hi    <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          hi  <= {cout, s[MULT_W-1:1]};
          lo  <= {s[0], lo[MULT_W-1:1]};
          cnt <= cnt + 4'd1;
          if (cnt == CNT_LAST) P <= {cout, s, lo[MULT_W-1:1]};
        end
        default: ;
      endcase
    end
  end

endmodule
